rob_multi_port: RTL and testbench

- Parametrised reorder buffer (ROB), the successor to the fixed four-writer ROB.
- Owns its own head/tail pointers and allocates tags in order at dispatch.
- Accepts NUM_WB independent completion channels and commits in order at the head.
- Provides rs/rt bypass lookup for the decode stage and performs precise-exception flush on commit of a faulting entry.

---
 rtl/rob_multi_port.sv | 153 +++++++++++++++
 tb/tb_rob_multi_port.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_port.sv
// Parametrised reorder buffer: in-order tag allocation, NUM_WB completion channels,
// in-order commit with precise-exception flush, and rs/rt bypass lookup for decode.
module rob_multi_port #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned NUM_WB = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned PC_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_valid,
    input  logic [REG_W-1:0]         alloc_dest,
    input  logic [PC_W-1:0]          alloc_pc,
    output logic                     alloc_ready,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_value,
    input  logic [NUM_WB-1:0]        wb_exc,
    input  logic [REG_W-1:0]         rs,
    input  logic [REG_W-1:0]         rt,
    output logic [1:0]               rs_state,
    output logic [1:0]               rt_state,
    output logic [DATA_W-1:0]        rs_value,
    output logic [DATA_W-1:0]        rt_value,
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [REG_W-1:0]         commit_dest,
    output logic [DATA_W-1:0]        commit_value,
    output logic [PC_W-1:0]          commit_pc,
    output logic                     commit_exc,
    output logic                     flush_out,
    output logic [TAG_W:0]           empty_entries
);

    localparam int unsigned CNT_W = TAG_W + 1;
    localparam logic [1:0] LK_NONE    = 2'd0;
    localparam logic [1:0] LK_PENDING = 2'd1;
    localparam logic [1:0] LK_READY   = 2'd2;

    typedef enum logic [1:0] {FREE, BUSY, COMPLETE} ent_e;

    ent_e              state   [DEPTH];
    logic [REG_W-1:0]  dest_q  [DEPTH];
    logic [PC_W-1:0]   pc_q    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic              exc_q   [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [TAG_W-1:0] idx;
    logic             alloc_fire;
    logic             commit_fire;
    logic             exc_commit;

    assign alloc_ready  = (count < CNT_W'(DEPTH));
    assign alloc_tag    = tail;
    assign commit_valid = (state[head] == COMPLETE);
    assign commit_dest  = commit_valid ? dest_q[head]  : '0;
    assign commit_value = commit_valid ? value_q[head] : '0;
    assign commit_pc    = commit_valid ? pc_q[head]    : '0;
    assign commit_exc   = commit_valid ? exc_q[head]   : 1'b0;

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = commit_valid && commit_ready;
    assign exc_commit  = commit_fire && exc_q[head];

    // Occupancy after this edge; a faulting commit empties the buffer outright.
    always_comb begin
        count_next = count;
        if (exc_commit) begin
            count_next = '0;
        end else begin
            case ({alloc_fire, commit_fire})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                state[i] <= FREE;
            end
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            empty_entries <= CNT_W'(DEPTH);
            flush_out     <= 1'b0;
        end else begin
            flush_out     <= exc_commit;
            count         <= count_next;
            empty_entries <= CNT_W'(DEPTH) - count_next;
            if (exc_commit) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    state[i] <= FREE;
                end
                head <= '0;
                tail <= '0;
            end else begin
                if (alloc_fire) begin
                    state[tail]   <= BUSY;
                    dest_q[tail]  <= alloc_dest;
                    pc_q[tail]    <= alloc_pc;
                    value_q[tail] <= '0;
                    exc_q[tail]   <= 1'b0;
                    tail          <= tail + TAG_W'(1);
                end
                // Ascending channel order lets the highest index win a shared tag.
                for (int unsigned i = 0; i < NUM_WB; i++) begin
                    if (wb_valid[i] && state[wb_tag[i*TAG_W +: TAG_W]] == BUSY) begin
                        state[wb_tag[i*TAG_W +: TAG_W]]   <= COMPLETE;
                        value_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_value[i*DATA_W +: DATA_W];
                        exc_q[wb_tag[i*TAG_W +: TAG_W]]   <= wb_exc[i];
                    end
                end
                if (commit_fire) begin
                    state[head] <= FREE;
                    head        <= head + TAG_W'(1);
                end
            end
        end
    end

    // Walk oldest to youngest so the youngest matching producer overrides.
    always_comb begin
        rs_state = LK_NONE;
        rs_value = '0;
        rt_state = LK_NONE;
        rt_value = '0;
        idx      = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + TAG_W'(k);
            if (CNT_W'(k) < count) begin
                if (rs != '0 && dest_q[idx] == rs) begin
                    rs_state = (state[idx] == COMPLETE) ? LK_READY : LK_PENDING;
                    rs_value = (state[idx] == COMPLETE) ? value_q[idx] : '0;
                end
                if (rt != '0 && dest_q[idx] == rt) begin
                    rt_state = (state[idx] == COMPLETE) ? LK_READY : LK_PENDING;
                    rt_value = (state[idx] == COMPLETE) ? value_q[idx] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_port.sv
// Directed bench for rob_multi_port: vector table for allocate/complete/commit/bypass,
// plus hand sequences for exception flush and pointer wrap-around.
module tb_rob_multi_port;

    logic         clk = 1'b0;
    logic         reset;
    logic         alloc_valid;
    logic [4:0]   alloc_dest;
    logic [31:0]  alloc_pc;
    logic         alloc_ready;
    logic [2:0]   alloc_tag;
    logic [3:0]   wb_valid;
    logic [11:0]  wb_tag;
    logic [127:0] wb_value;
    logic [3:0]   wb_exc;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [1:0]   rs_state;
    logic [1:0]   rt_state;
    logic [31:0]  rs_value;
    logic [31:0]  rt_value;
    logic         commit_valid;
    logic         commit_ready;
    logic [4:0]   commit_dest;
    logic [31:0]  commit_value;
    logic [31:0]  commit_pc;
    logic         commit_exc;
    logic         flush_out;
    logic [3:0]   empty_entries;

    int errors = 0;
    int checks = 0;

    rob_multi_port dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_exc(wb_exc),
        .rs(rs), .rt(rt), .rs_state(rs_state), .rt_state(rt_state),
        .rs_value(rs_value), .rt_value(rt_value),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_dest(commit_dest), .commit_value(commit_value), .commit_pc(commit_pc),
        .commit_exc(commit_exc), .flush_out(flush_out), .empty_entries(empty_entries)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         av;
        logic [4:0]   ad;
        logic [31:0]  apc;
        logic [3:0]   wv;
        logic [11:0]  wt;
        logic [127:0] wval;
        logic [3:0]   we;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic         cr;
        logic         ardy;
        logic [2:0]   atag;
        logic         cv;
        logic [31:0]  cval;
        logic [4:0]   cdest;
        logic [3:0]   empt;
        logic [1:0]   rs_st;
        logic [31:0]  rs_val;
        logic [1:0]   rt_st;
        logic [31:0]  rt_val;
        logic         flush;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid  = 1'b0;
        alloc_dest   = 5'd0;
        alloc_pc     = 32'h0;
        wb_valid     = 4'h0;
        wb_tag       = 12'h0;
        wb_value     = 128'h0;
        wb_exc       = 4'h0;
        rs           = 5'd0;
        rt           = 5'd0;
        commit_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_alloc_ready", 0, 32'(alloc_ready), 32'd1);
        chk("rst_alloc_tag", 0, 32'(alloc_tag), 32'd0);
        chk("rst_commit_valid", 0, 32'(commit_valid), 32'd0);
        chk("rst_commit_exc", 0, 32'(commit_exc), 32'd0);
        chk("rst_commit_dest", 0, 32'(commit_dest), 32'd0);
        chk("rst_commit_value", 0, commit_value, 32'd0);
        chk("rst_commit_pc", 0, commit_pc, 32'd0);
        chk("rst_rs_state", 0, 32'(rs_state), 32'd0);
        chk("rst_rt_value", 0, rt_value, 32'd0);
        chk("rst_flush", 0, 32'(flush_out), 32'd0);
        chk("rst_empty", 0, 32'(empty_entries), 32'd8);

        // rst av ad apc wv wt wval we rs rt cr | ardy atag cv cval cdest empt rs_st rs_val rt_st rt_val flush
        for (int k = 0; k < 8; k++) begin
            tbl.push_back('{1'b0, 1'b1, 5'(k + 1), 32'(256 + 4 * k), 4'h0, 12'h0, 128'h0, 4'h0, 5'd0, 5'd0, 1'b0,
                            1'b1, 3'(k), 1'b0, 32'h0, 5'd0, 4'(8 - k), 2'd0, 32'h0, 2'd0, 32'h0, 1'b0});
        end
        tbl.push_back('{1'b0, 1'b1, 5'd9, 32'h120, 4'h0, 12'h0, 128'h0, 4'h0, 5'd5, 5'd0, 1'b0,
                        1'b0, 3'd0, 1'b0, 32'h0, 5'd0, 4'd0, 2'd1, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'b0100, 12'h040, {32'h0, 32'h55, 64'h0}, 4'h0, 5'd2, 5'd0, 1'b1,
                        1'b0, 3'd0, 1'b0, 32'h0, 5'd0, 4'd0, 2'd1, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'b0001, 12'h000, {96'h0, 32'h11}, 4'h0, 5'd2, 5'd0, 1'b1,
                        1'b0, 3'd0, 1'b0, 32'h0, 5'd0, 4'd0, 2'd2, 32'h55, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 5'd9, 32'h124, 4'h0, 12'h0, 128'h0, 4'h0, 5'd1, 5'd0, 1'b1,
                        1'b0, 3'd0, 1'b1, 32'h11, 5'd1, 4'd0, 2'd2, 32'h11, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 128'h0, 4'h0, 5'd0, 5'd0, 1'b1,
                        1'b1, 3'd0, 1'b1, 32'h55, 5'd2, 4'd1, 2'd0, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 128'h0, 4'h0, 5'd8, 5'd0, 1'b1,
                        1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 4'd2, 2'd1, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'b1001, 12'h402, {32'hB, 64'h0, 32'hA}, 4'h0, 5'd0, 5'd0, 1'b0,
                        1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 4'd2, 2'd0, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 128'h0, 4'h0, 5'd3, 5'd0, 1'b1,
                        1'b1, 3'd0, 1'b1, 32'hB, 5'd3, 4'd2, 2'd2, 32'hB, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 128'h0, 4'h0, 5'd4, 5'd0, 1'b0,
                        1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 4'd3, 2'd1, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 5'd3, 32'h200, 4'h0, 12'h0, 128'h0, 4'h0, 5'd4, 5'd0, 1'b0,
                        1'b1, 3'd0, 1'b0, 32'h0, 5'd0, 4'd8, 2'd0, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 5'd3, 32'h204, 4'h0, 12'h0, 128'h0, 4'h0, 5'd3, 5'd0, 1'b0,
                        1'b1, 3'd1, 1'b0, 32'h0, 5'd0, 4'd7, 2'd1, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'b0010, 12'h000, {64'h0, 32'h7, 32'h0}, 4'h0, 5'd3, 5'd0, 1'b0,
                        1'b1, 3'd2, 1'b0, 32'h0, 5'd0, 4'd6, 2'd1, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'b1000, 12'h200, {32'h9, 96'h0}, 4'h0, 5'd3, 5'd0, 1'b0,
                        1'b1, 3'd2, 1'b1, 32'h7, 5'd3, 4'd6, 2'd1, 32'h0, 2'd0, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 128'h0, 4'h0, 5'd3, 5'd3, 1'b0,
                        1'b1, 3'd2, 1'b1, 32'h7, 5'd3, 4'd6, 2'd2, 32'h9, 2'd2, 32'h9, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 128'h0, 4'h0, 5'd0, 5'd3, 1'b0,
                        1'b1, 3'd2, 1'b1, 32'h7, 5'd3, 4'd6, 2'd0, 32'h0, 2'd2, 32'h9, 1'b0});

        foreach (tbl[i]) begin
            @(negedge clk);
            reset        = tbl[i].rst;
            alloc_valid  = tbl[i].av;
            alloc_dest   = tbl[i].ad;
            alloc_pc     = tbl[i].apc;
            wb_valid     = tbl[i].wv;
            wb_tag       = tbl[i].wt;
            wb_value     = tbl[i].wval;
            wb_exc       = tbl[i].we;
            rs           = tbl[i].rs;
            rt           = tbl[i].rt;
            commit_ready = tbl[i].cr;
            #1;
            chk("alloc_ready", i, 32'(alloc_ready), 32'(tbl[i].ardy));
            chk("alloc_tag", i, 32'(alloc_tag), 32'(tbl[i].atag));
            chk("commit_valid", i, 32'(commit_valid), 32'(tbl[i].cv));
            chk("commit_value", i, commit_value, tbl[i].cval);
            chk("commit_dest", i, 32'(commit_dest), 32'(tbl[i].cdest));
            chk("empty_entries", i, 32'(empty_entries), 32'(tbl[i].empt));
            chk("rs_state", i, 32'(rs_state), 32'(tbl[i].rs_st));
            chk("rs_value", i, rs_value, tbl[i].rs_val);
            chk("rt_state", i, 32'(rt_state), 32'(tbl[i].rt_st));
            chk("rt_value", i, rt_value, tbl[i].rt_val);
            chk("flush_out", i, 32'(flush_out), 32'(tbl[i].flush));
        end

        // Exception commit flushes everything, dropping same-cycle alloc and completion.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            alloc_valid = 1'b1;
            alloc_dest  = 5'(k + 1);
            alloc_pc    = 32'(32'h300 + 4 * k);
            @(negedge clk);
        end
        idle_inputs();
        wb_valid = 4'b0001;
        wb_tag   = 12'h000;
        wb_value = 128'h33;
        wb_exc   = 4'b0001;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("exc_commit_valid", 0, 32'(commit_valid), 32'd1);
        chk("exc_commit_exc", 0, 32'(commit_exc), 32'd1);
        chk("exc_commit_pc", 0, commit_pc, 32'h300);
        chk("exc_commit_value", 0, commit_value, 32'h33);
        chk("exc_flush_before", 0, 32'(flush_out), 32'd0);
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        alloc_dest   = 5'd5;
        alloc_pc     = 32'h400;
        wb_valid     = 4'b0010;
        wb_tag       = 12'h008;
        wb_value     = {64'h0, 32'h44, 32'h0};
        @(negedge clk);
        idle_inputs();
        wb_valid = 4'b0100;
        wb_tag   = 12'h040;
        wb_value = {32'h0, 32'h77, 64'h0};
        rs       = 5'd2;
        rt       = 5'd5;
        #1;
        chk("exc_flush_pulse", 1, 32'(flush_out), 32'd1);
        chk("exc_empty", 1, 32'(empty_entries), 32'd8);
        chk("exc_alloc_tag", 1, 32'(alloc_tag), 32'd0);
        chk("exc_alloc_ready", 1, 32'(alloc_ready), 32'd1);
        chk("exc_commit_valid", 1, 32'(commit_valid), 32'd0);
        chk("exc_rs_state", 1, 32'(rs_state), 32'd0);
        chk("exc_rt_state", 1, 32'(rt_state), 32'd0);
        @(negedge clk);
        idle_inputs();
        rs = 5'd1;
        #1;
        chk("exc_flush_drop", 2, 32'(flush_out), 32'd0);
        chk("exc_commit_valid", 2, 32'(commit_valid), 32'd0);
        chk("exc_empty", 2, 32'(empty_entries), 32'd8);
        chk("exc_rs_state", 2, 32'(rs_state), 32'd0);

        // Full-rate alloc/complete/commit stream across several pointer wraps.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            int na;
            int nc;
            idle_inputs();
            commit_ready = 1'b1;
            if (c < 20) begin
                alloc_valid = 1'b1;
                alloc_dest  = 5'((c % 7) + 1);
                alloc_pc    = 32'(32'h1000 + 4 * c);
            end
            if (c >= 1 && c <= 20) begin
                wb_valid = 4'(1 << (c % 4));
                wb_tag   = 12'((c - 1) % 8) << (3 * (c % 4));
                wb_value = 128'(c) << (32 * (c % 4));
            end
            na = (c < 20) ? c : 20;
            nc = (c > 2) ? c - 2 : 0;
            #1;
            chk("wrap_alloc_ready", c, 32'(alloc_ready), 32'd1);
            chk("wrap_alloc_tag", c, 32'(alloc_tag), 32'(na % 8));
            chk("wrap_empty", c, 32'(empty_entries), 32'(8 - (na - nc)));
            chk("wrap_commit_valid", c, 32'(commit_valid), 32'(c >= 2));
            if (c >= 2) begin
                chk("wrap_commit_pc", c, commit_pc, 32'(32'h1000 + 4 * (c - 2)));
                chk("wrap_commit_value", c, commit_value, 32'(c - 1));
                chk("wrap_commit_dest", c, 32'(commit_dest), 32'(((c - 2) % 7) + 1));
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("wrap_drained_empty", 0, 32'(empty_entries), 32'd8);
        chk("wrap_drained_valid", 0, 32'(commit_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
